ifetch_stage: RTL
=================

# ifetch_stage

Instruction-fetch stage sitting directly upstream of the combinational instruction memory. It owns the program counter, drives the word address into the memory, captures the returned 32-bit instruction into an IF/ID output register, and hands it downstream over a valid/ready handshake. It supports control-flow redirects from later stages, a start/halt run-control FSM, and a delivered-instruction counter.

## Interface
- `AW`, 5: PC width in words; the memory is word-indexed, one word per address.
- `HALT_OPCODE`, 6'b111111: value of `instruction[31:26]` that marks a halt instruction.
- `CNT_W`, 16: width of `fetch_count`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; moves IDLE→RUN.
- `instr_addr` out 32: `{(32-AW)'b0, pc}`; purely combinational from `pc`.
- `instruction` in 32: memory read data for `instr_addr`, valid in the same cycle.
- `redirect_valid` in 1: a branch/jump is taken this cycle.
- `redirect_target` in AW: new PC when `redirect_valid`.
- `out_valid` out 1: the IF/ID register holds an instruction.
- `out_ready` in 1: downstream accepts this cycle.
- `out_instr` out 32: registered instruction.
- `out_pc` out AW: PC that `out_instr` was fetched from.
- `halted` out 1: FSM is in HALT.
- `fetch_count` out CNT_W: count of completed handshakes (`out_valid && out_ready`); wraps.

## Operation
- FSM states and transitions:
  - IDLE (reset) → RUN on `start`.
  - RUN → HALT when a halt instruction is loaded.
  - HALT → RUN on `redirect_valid`.
  - `start` is ignored outside IDLE.
- `load_en = !out_valid || out_ready`.
- In RUN with `load_en` and no redirect:
  - `out_instr <= instruction`, `out_pc <= pc`, `out_valid <= 1`.
  - `pc <= pc + 1` modulo 2^AW; `pc = 2^AW-1` wraps to 0.
- Halt instruction (`instruction[31:26] == HALT_OPCODE`) loaded in RUN:
  - Delivered normally, with `out_valid <= 1`.
  - `pc` is not incremented; the next state is HALT.
- In RUN with `!load_en` (backpressure): `pc` and the output register hold; `instr_addr` stays stable.
- `redirect_valid` in RUN or HALT has priority over everything:
  - `pc <= redirect_target`, `out_valid <= 0`.
  - The held instruction is flushed even if `out_ready` is 0. A flushed instruction does not increment `fetch_count`.
- `redirect_valid` in IDLE: `pc <= redirect_target` and the state stays IDLE. Together with `start`, the PC loads and the state goes to RUN.
- In IDLE/HALT with `out_valid && out_ready`: `out_valid <= 0`. No new fetch occurs.
- `fetch_count` increments on every `out_valid && out_ready`, including the halt instruction's handshake.

## Timing
- Reset values: `pc=0`, state IDLE, `out_valid=0`, `out_instr=0`, `out_pc=0`, `halted=0`, `fetch_count=0`, `instr_addr=0`.
- Reset takes effect immediately and asynchronously, including mid-stall. The first post-reset fetch needs a new `start`.
- Latency:
  - `start` sampled at edge N → RUN from N.
  - `pc` presented during cycle N→N+1.
  - `out_valid=1` after edge N+1.
- Throughput is 1 instruction/cycle while `out_ready=1`.
- Redirect sampled at edge R → `out_valid=0` after R. The target is fetched during R→R+1 and is valid after R+1. This gives one bubble per redirect.
- `out_*` are stable while `out_valid && !out_ready`.
- `halted` asserts the cycle after the halt instruction is loaded, concurrently with it appearing on `out_instr`.

## Structure
- `fetch_pkg`:
  - FSM state enum (IDLE, RUN, HALT).
  - Opcode field position constants (`OPC_HI=31`, `OPC_LO=26`).
  - Default `HALT_OPCODE`.
- One natural sub-module: `ifid_reg`. It holds the output register with load/flush/valid/ready logic; PC and FSM stay in `ifetch_stage`.

## Test plan
- **Straight-line:** memory `[0]=32'h02800007`, `[1]=32'h02811009`, `[2]=32'h00802001`, `[3]=32'hFC000000` (halt); `start`, `out_ready=1` → `out_pc` 0,1,2,3 on consecutive cycles; `halted=1`; `fetch_count=4`; `pc` stays 3.
- **Backpressure:** drop `out_ready` for 3 cycles while `out_pc=1` → `out_instr=32'h02811009` held; `instr_addr=2` stable; resume → `out_pc=2` next cycle; no loss, no duplicate.
- **Redirect while stalled:** `out_valid=1`, `out_ready=0`, redirect to 5 → `out_valid=0` next cycle; `out_pc=5` one cycle later; `fetch_count` unchanged by the flush.
- **Halt restart:** in HALT, `redirect_valid` with target 0 → RUN; `halted=0`; `out_pc=0` one cycle later.
- **Wrap-around:** redirect to 31 (`AW=5`) → fetches 31 then 0.
- **Async reset:** assert `rst_n=0` mid-stream between edges → all outputs reset immediately; `start` ignored until `rst_n=1`; `start` then fetches from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: run-control states,
// opcode field position and the default halt opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] DEFAULT_HALT_OPCODE = 6'b111111;

  // True when the opcode field of instr matches the given halt opcode.
  function automatic logic is_halt(input logic [31:0] instr,
                                   input logic [OPC_W-1:0] halt_opc);
    return (instr[OPC_HI:OPC_LO] == halt_opc);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID output register: holds one fetched instruction and its PC, presents it
// downstream over valid/ready, supports flush, and counts completed handshakes.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             flush,
  input  logic [31:0]      in_instr,
  input  logic [AW-1:0]    in_pc,
  input  logic             out_ready,
  output logic             load_en,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [AW-1:0]    out_pc,
  output logic [CNT_W-1:0] fetch_count
);

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fire;

  // The register can accept a new instruction when empty or being drained.
  assign load_en = !valid_q || out_ready;

  // A flushed instruction never counts as delivered, even if ready was high.
  assign fire = valid_q && out_ready && !flush;

  // Next-state for the holding register and the delivery counter.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (fire) begin
      valid_d = 1'b0;
    end
    if (fire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = pc_q;
  assign fetch_count = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC and the IDLE/RUN/HALT run-control FSM,
// addresses the combinational instruction memory and feeds the IF/ID register.
module ifetch_stage
  import fetch_pkg::*;
#(
  parameter int               AW          = 5,
  parameter logic [OPC_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [31:0]      instr_addr,
  input  logic [31:0]      instruction,
  input  logic             redirect_valid,
  input  logic [AW-1:0]    redirect_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [AW-1:0]    out_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          load_en;
  logic          fetch;
  logic          fetch_halt;
  logic          flush;

  // A fetch happens only while running, with room downstream, and no redirect
  // overriding it this cycle.
  assign fetch      = (state_q == ST_RUN) && load_en && !redirect_valid;
  assign fetch_halt = fetch && is_halt(instruction, HALT_OPCODE);

  // Redirects flush the output register only once the stage has been started;
  // in IDLE the register is empty anyway.
  assign flush = redirect_valid && (state_q != ST_IDLE);

  // Run-control next state and PC update; redirect beats everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!redirect_valid && fetch_halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (redirect_valid) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (fetch && !fetch_halt) begin
      pc_d = pc_q + AW'(1);
    end
  end

  // FSM and PC registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_addr = {{(32-AW){1'b0}}, pc_q};
  assign halted     = (state_q == ST_HALT);

  ifid_reg #(
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_ifid_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (fetch),
    .flush       (flush),
    .in_instr    (instruction),
    .in_pc       (pc_q),
    .out_ready   (out_ready),
    .load_en     (load_en),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .fetch_count (fetch_count)
  );

endmodule
